mul_sequencer: RTL

- Controls the execute stage when the current instruction is a multiply; the array multiplier is a combinational multicycle timing path.
- Latches the operands, freezes the front of the pipeline for a fixed number of settle cycles, then steers the product through the result mux into EX/MEM.
- Passes non-multiply instructions through with zero added latency.
- Also reports the pending multiply's destination register to the hazard/forwarding logic.

---
 rtl/mul_sequencer_pkg.sv | 13 +
 rtl/mul_settle_counter.sv | 31 +++
 rtl/mul_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared pipeline definitions for the multiply sequencer: FSM state encoding
// and the register-address width used by hazard/forwarding consumers.
package mul_sequencer_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul_settle_counter.sv
// Loadable down-counter timing the multiplier settle window; tc flags the
// last BUSY cycle (count == 1).
module mul_settle_counter
  import mul_sequencer_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // Saturate at zero so the count never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/mul_sequencer.sv
// Execute-stage multiply sequencer: latches operands, stalls the front end for
// the multiplier settle time, then selects the product into EX/MEM.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_mul,
  input  logic [REG_W-1:0] ex_destReg,
  input  logic             kill,
  output logic             op_load,
  output logic             stall,
  output logic             ex_bubble,
  output logic             res_sel,
  output logic             busy,
  output logic [REG_W-1:0] pend_dest,
  output logic             pend_valid
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MUL_LATENCY - 1);
  localparam bit               SINGLE   = (MUL_LATENCY == 1);

  state_t state;
  state_t state_next;
  logic   start;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_tc;
  logic   pend_set;
  logic   pend_clr;

  // Gating with reset keeps every output at 0 while reset is held.
  assign start = ex_valid & ex_mul & ~kill & ~reset;

  mul_settle_counter #(
    .CNT_W (CNT_W)
  ) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    op_load    = 1'b0;
    stall      = 1'b0;
    ex_bubble  = 1'b0;
    res_sel    = 1'b0;
    busy       = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          op_load    = 1'b1;
          stall      = 1'b1;
          ex_bubble  = 1'b1;
          busy       = 1'b1;
          pend_set   = 1'b1;
          cnt_load   = ~SINGLE;
          state_next = SINGLE ? DONE : BUSY;
        end
      end
      BUSY: begin
        busy      = 1'b1;
        ex_bubble = 1'b1;
        if (kill) begin
          pend_clr   = 1'b1;
          state_next = IDLE;
        end else begin
          stall   = 1'b1;
          cnt_dec = 1'b1;
          if (cnt_tc) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        busy       = 1'b1;
        pend_clr   = 1'b1;
        state_next = IDLE;
        // A flush here drops the product and bubbles EX/MEM instead.
        if (kill) begin
          ex_bubble = 1'b1;
        end else begin
          res_sel = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_dest  <= '0;
      pend_valid <= 1'b0;
    end else if (pend_set) begin
      pend_dest  <= ex_destReg;
      pend_valid <= 1'b1;
    end else if (pend_clr) begin
      pend_valid <= 1'b0;
    end
  end

endmodule
